spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_slave.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// SPI slave that runs entirely in the i_Clk domain. The SPI pins are
// oversampled through 2-flop synchronizers, and edges are found by comparing
// each synchronized value with a third flop. One byte is buffered for
// transmit in a holding register. Received bytes are reported with a
// one-cycle strobe.
//
// Parameters
//   SPI_MODE       0..3. CPOL = mode 2 or 3, CPHA = mode 1 or 3.
//
// Ports
//   i_Clk          system clock (single clock domain)
//   i_Rst          synchronous active-high reset
//   i_TX_Byte      byte to return on MISO
//   i_TX_DV        one-cycle load strobe for i_TX_Byte
//   o_TX_Ready     holding register empty
//   o_RX_DV        one-cycle pulse: o_RX_Byte has just been updated
//   o_RX_Byte      last complete byte received on MOSI
//   i_SPI_Clk      SPI clock from the master (asynchronous)
//   i_SPI_CS_n     chip select, active low (asynchronous)
//   i_SPI_MOSI     master-out data (asynchronous)
//   o_SPI_MISO     slave-out data
//   o_SPI_MISO_En  MISO pad output enable, high only while selected
//
// Handshake: a byte is accepted when i_TX_DV=1 and o_TX_Ready=1 in the same
// cycle. o_TX_Ready reads 0 from the following cycle. i_TX_DV is ignored
// while o_TX_Ready=0.
//
// The SPI half-period must be at least 4 i_Clk periods.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_slave #(
    parameter int SPI_MODE = 0
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_En
);

    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

    typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    state_t     r_state;
    state_t     w_next_state;

    // Synchronizers: stage 1 and stage 2 form the synchronizer. Stage 3 is
    // the delayed copy that edges are compared against.
    logic       r_clk_s1, r_clk_s2, r_clk_s3;
    logic       r_cs_s1,  r_cs_s2,  r_cs_s3;
    logic       r_mosi_s1, r_mosi_s2, r_mosi_s3;

    // Registered edge pulses, aligned with r_mosi_s3.
    logic       r_lead_p;
    logic       r_trail_p;
    logic       r_cs_fall_p;

    // The CS synchronizer is preset high on reset. If the pin is already low
    // when reset is released, the flush of that preset would look like a
    // falling edge. A fall only counts after a genuine high level has been
    // seen on the pin since reset. r_s1_valid marks that stage 1 now holds
    // a real pin sample rather than the reset preset.
    logic       r_s1_valid;
    logic       r_cs_armed;

    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic [7:0] r_hold;
    logic       r_hold_full;
    logic       r_miso;
    logic [7:0] r_rx_byte;
    logic       r_rx_dv;

    logic       w_sample_p;
    logic       w_shift_p;
    logic       w_active;
    logic       w_sample;
    logic       w_shift;
    logic       w_load;

    assign w_sample_p = CPHA ? r_trail_p : r_lead_p;
    assign w_shift_p  = CPHA ? r_lead_p  : r_trail_p;

    // ------------------------------------------------------------------
    // Synchronizers and edge detection
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_clk_s1    <= CPOL;
            r_clk_s2    <= CPOL;
            r_clk_s3    <= CPOL;
            r_cs_s1     <= 1'b1;
            r_cs_s2     <= 1'b1;
            r_cs_s3     <= 1'b1;
            r_mosi_s1   <= 1'b0;
            r_mosi_s2   <= 1'b0;
            r_mosi_s3   <= 1'b0;
            r_lead_p    <= 1'b0;
            r_trail_p   <= 1'b0;
            r_cs_fall_p <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_cs_armed  <= 1'b0;
        end else begin
            r_clk_s1    <= i_SPI_Clk;
            r_clk_s2    <= r_clk_s1;
            r_clk_s3    <= r_clk_s2;
            r_cs_s1     <= i_SPI_CS_n;
            r_cs_s2     <= r_cs_s1;
            r_cs_s3     <= r_cs_s2;
            r_mosi_s1   <= i_SPI_MOSI;
            r_mosi_s2   <= r_mosi_s1;
            r_mosi_s3   <= r_mosi_s2;
            r_s1_valid  <= 1'b1;
            if (r_s1_valid && r_cs_s1) begin
                r_cs_armed <= 1'b1;
            end
            // Leading edge leaves the idle level. Trailing edge returns to it.
            r_lead_p    <= (r_clk_s2 != CPOL) && (r_clk_s3 == CPOL);
            r_trail_p   <= (r_clk_s2 == CPOL) && (r_clk_s3 != CPOL);
            r_cs_fall_p <= r_cs_armed && r_cs_s3 && !r_cs_s2;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (r_cs_s3) begin
            w_next_state = ST_IDLE;
        end else if ((r_state == ST_IDLE) && r_cs_fall_p) begin
            w_next_state = ST_ACTIVE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs / datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        w_active = (r_state == ST_ACTIVE) && !r_cs_s3;
        w_sample = w_active && w_sample_p;
        // For CPHA=0, the trailing edge just after a load must not shift.
        // Bit 7 was already presented by the load.
        w_shift  = w_active && w_shift_p && (CPHA || (r_bit_cnt != 3'd7));
        w_load   = ((r_state == ST_IDLE) && (w_next_state == ST_ACTIVE)) ||
                   (w_sample && (r_bit_cnt == 3'd0));
        o_SPI_MISO_En = (r_state == ST_ACTIVE);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_bit_cnt   <= 3'd7;
            r_rx_shift  <= 8'h00;
            r_tx_shift  <= 8'h00;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_miso      <= 1'b0;
            r_rx_byte   <= 8'h00;
            r_rx_dv     <= 1'b0;
        end else begin
            r_rx_dv <= 1'b0;

            if (w_sample) begin
                r_rx_shift <= {r_rx_shift[6:0], r_mosi_s3};
                if (r_bit_cnt == 3'd0) begin
                    r_rx_byte <= {r_rx_shift[6:0], r_mosi_s3};
                    r_rx_dv   <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt - 3'd1;
                end
            end

            if (w_load) begin
                r_bit_cnt <= 3'd7;
                if (r_hold_full) begin
                    r_tx_shift  <= r_hold;
                    r_hold_full <= 1'b0;
                    if (!CPHA) begin
                        r_miso <= r_hold[7];
                    end
                end else begin
                    r_tx_shift <= 8'h00;
                    if (!CPHA) begin
                        r_miso <= 1'b0;
                    end
                end
            end else if (w_shift) begin
                // CPHA=0: MSB is already on the pin, so present the next bit.
                // CPHA=1: present the current MSB.
                r_miso     <= CPHA ? r_tx_shift[7] : r_tx_shift[6];
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end

            // This can only fire while holding is empty. A load in the same
            // cycle has therefore already taken 0x00, and the new byte waits
            // for the next load.
            if (i_TX_DV && !r_hold_full) begin
                r_hold      <= i_TX_Byte;
                r_hold_full <= 1'b1;
            end
        end
    end

    assign o_TX_Ready = !r_hold_full;
    assign o_RX_DV    = r_rx_dv;
    assign o_RX_Byte  = r_rx_byte;
    assign o_SPI_MISO = r_miso;

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps

module tb_spi_slave;

  localparam time CLK_P = 10;
  localparam time HP    = 80;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_dv = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       sel3 = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int dv_cnt = 0;
  logic [7:0] rx_log[$];

  logic       ready0, dv0, miso0, en0;
  logic [7:0] rxb0;
  logic       ready3, dv3, miso3, en3;
  logic [7:0] rxb3;

  wire        w_sclk0 = sel3 ? 1'b0 : sclk;
  wire        w_cs0   = sel3 ? 1'b1 : cs_n;
  wire        w_sclk3 = sel3 ? sclk : 1'b1;
  wire        w_cs3   = sel3 ? cs_n : 1'b1;
  wire        w_dv0   = tx_dv & ~sel3;
  wire        w_dv3   = tx_dv & sel3;

  wire        w_ready = sel3 ? ready3 : ready0;
  wire        w_rxdv  = sel3 ? dv3    : dv0;
  wire [7:0]  w_rxb   = sel3 ? rxb3   : rxb0;
  wire        w_miso  = sel3 ? miso3  : miso0;
  wire        w_en    = sel3 ? en3    : en0;

  spi_slave #(.SPI_MODE(0)) u_dut0 (
    .i_Clk(clk), .i_Rst(rst), .i_TX_Byte(tx_byte), .i_TX_DV(w_dv0),
    .o_TX_Ready(ready0), .o_RX_DV(dv0), .o_RX_Byte(rxb0),
    .i_SPI_Clk(w_sclk0), .i_SPI_CS_n(w_cs0), .i_SPI_MOSI(mosi),
    .o_SPI_MISO(miso0), .o_SPI_MISO_En(en0)
  );

  spi_slave #(.SPI_MODE(3)) u_dut3 (
    .i_Clk(clk), .i_Rst(rst), .i_TX_Byte(tx_byte), .i_TX_DV(w_dv3),
    .o_TX_Ready(ready3), .o_RX_DV(dv3), .o_RX_Byte(rxb3),
    .i_SPI_Clk(w_sclk3), .i_SPI_CS_n(w_cs3), .i_SPI_MOSI(mosi),
    .o_SPI_MISO(miso3), .o_SPI_MISO_En(en3)
  );

  always #(CLK_P / 2) clk = ~clk;

  always @(negedge clk) begin
    if (w_rxdv) begin
      dv_cnt++;
      rx_log.push_back(w_rxb);
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tally(input bit ok, input string tag);
    n_vec++;
    if (!ok) begin
      n_err++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic load_tx(input logic [7:0] b);
    @(posedge clk);
    #1;
    tx_byte = b;
    tx_dv   = 1'b1;
    @(posedge clk);
    #1;
    tx_dv   = 1'b0;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    #HP;
  endtask

  task automatic cs_high();
    #HP;
    cs_n = 1'b1;
    #(4 * HP);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      if (!sel3) begin
        #HP;
        rx[i] = w_miso;
        sclk = 1'b1;
        #HP;
        sclk = 1'b0;
      end else begin
        sclk = 1'b0;
        #HP;
        rx[i] = w_miso;
        sclk = 1'b1;
        #HP;
      end
    end
  endtask

  task automatic clr_mon();
    dv_cnt = 0;
    rx_log.delete();
  endtask

  logic [7:0] rd;
  logic [7:0] rd2;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tally(w_ready === 1'b1, "rst_ready");
    tally(w_rxdv === 1'b0, "rst_rxdv");
    tally(w_rxb === 8'h00, "rst_rxbyte");
    tally(w_miso === 1'b0, "rst_miso");
    tally(w_en === 1'b0, "rst_en");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    clr_mon();
    load_tx(8'h3C);
    tally(w_ready === 1'b0, "m0_ready_after_load");
    cs_low();
    tally(w_en === 1'b1, "m0_en_active");
    tally(w_ready === 1'b1, "m0_ready_after_entry");
    spi_bits(8'hA5, 8, rd);
    cs_high();
    tally(rd === 8'h3C, "m0_miso_byte");
    tally(w_rxb === 8'hA5, "m0_rx_byte");
    tally(dv_cnt == 1, "m0_dv_count");
    tally(w_en === 1'b0, "m0_en_idle");

    clr_mon();
    cs_low();
    spi_bits(8'hFF, 8, rd);
    cs_high();
    tally(rd === 8'h00, "empty_miso_byte");
    tally(w_rxb === 8'hFF, "empty_rx_byte");
    tally(dv_cnt == 1, "empty_dv_count");

    clr_mon();
    load_tx(8'h11);
    cs_low();
    tally(w_ready === 1'b1, "b2b_ready_after_entry");
    load_tx(8'h22);
    tally(w_ready === 1'b0, "b2b_ready_held");
    spi_bits(8'hC0, 8, rd);
    spi_bits(8'h03, 8, rd2);
    cs_high();
    tally(rd === 8'h11, "b2b_miso_byte0");
    tally(rd2 === 8'h22, "b2b_miso_byte1");
    tally(dv_cnt == 2, "b2b_dv_count");
    if (rx_log.size() == 2) begin
      tally(rx_log[0] === 8'hC0, "b2b_rx0");
      tally(rx_log[1] === 8'h03, "b2b_rx1");
    end else begin
      tally(rx_log.size() == 2, "b2b_rx_log_size");
    end
    tally(w_ready === 1'b1, "b2b_ready_end");

    clr_mon();
    cs_low();
    spi_bits(8'hF0, 4, rd);
    cs_high();
    tally(dv_cnt == 0, "abort_dv_count");
    tally(w_en === 1'b0, "abort_en");
    tally(w_rxb === 8'h03, "abort_rx_unchanged");
    cs_low();
    spi_bits(8'h96, 8, rd);
    cs_high();
    tally(w_rxb === 8'h96, "abort_next_rx");
    tally(dv_cnt == 1, "abort_next_dv");

    clr_mon();
    load_tx(8'h44);
    cs_low();
    spi_bits(8'hFF, 5, rd);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tally(w_ready === 1'b1, "midrst_ready");
    tally(w_rxdv === 1'b0, "midrst_rxdv");
    tally(w_rxb === 8'h00, "midrst_rxbyte");
    tally(w_miso === 1'b0, "midrst_miso");
    tally(w_en === 1'b0, "midrst_en");
    @(posedge clk);
    #1;
    rst = 1'b0;
    spi_bits(8'hFF, 3, rd);
    tally(w_en === 1'b0, "midrst_no_resume_en");
    tally(dv_cnt == 0, "midrst_no_dv");
    cs_high();
    load_tx(8'hE7);
    cs_low();
    spi_bits(8'h5A, 8, rd);
    cs_high();
    tally(w_rxb === 8'h5A, "postrst_rx");
    tally(rd === 8'hE7, "postrst_miso_byte");
    tally(dv_cnt == 1, "postrst_dv");

    sclk = 1'b1;
    sel3 = 1'b1;
    #(4 * HP);
    clr_mon();
    load_tx(8'h81);
    tally(w_ready === 1'b0, "m3_ready_after_load");
    cs_low();
    tally(w_en === 1'b1, "m3_en_active");
    spi_bits(8'h7E, 8, rd);
    cs_high();
    tally(rd === 8'h81, "m3_miso_byte");
    tally(w_rxb === 8'h7E, "m3_rx_byte");
    tally(dv_cnt == 1, "m3_dv_count");
    tally(w_en === 1'b0, "m3_en_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
